// File: rtl/iob_native_split.sv
// Splits a native valid/ready CPU port onto one instruction bus and 2**SEL_W data buses.
// Latency: one request in flight; a write takes 2 cycles and a zero-wait read takes 3.
// Backpressure: REQ is held until the selected slave's m_ready arrives.
// Optional abort of unanswered requests and the sticky err flag: IOB_NATIVE_SPLIT_TIMEOUT_EN.
module iob_native_split #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int SEL_W   = 1,
  parameter  int TIMEOUT = 1024,
  localparam int WSTRB_W = DATA_W / 8,
  localparam int N       = (2 ** SEL_W) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cpu_valid,
  input  logic                   cpu_instr,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic [WSTRB_W-1:0]     cpu_wstrb,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  output logic [N-1:0]           m_avalid,
  output logic [N*ADDR_W-1:0]    m_addr,
  output logic [N*DATA_W-1:0]    m_wdata,
  output logic [N*WSTRB_W-1:0]   m_wstrb,
  input  logic [N-1:0]           m_ready,
  input  logic [N*DATA_W-1:0]    m_rdata,
  input  logic [N-1:0]           m_rvalid,
  output logic                   err
);
  localparam int SLV_W = SEL_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [WSTRB_W-1:0] r_wstrb;
  logic [SLV_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_rdata;

  logic [SLV_W-1:0]   w_sel;
  logic               w_rdy;
  logic               w_rvalid;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_tmo;

  // Slave 0 is the fetch bus; data slaves start at index 1.
  assign w_sel    = cpu_instr ? '0 : SLV_W'(cpu_addr[ADDR_W-1 -: SEL_W]) + SLV_W'(1);
  assign w_rdy    = m_ready[r_sel];
  assign w_rvalid = m_rvalid[r_sel];
  assign w_rdata  = m_rdata[r_sel*DATA_W +: DATA_W];

`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign err   = r_err;

  // Held at zero in IDLE so it reads zero on the first REQ cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      else                                      r_cnt <= '0;
      if (w_tmo && ((r_state == S_REQ && !w_rdy) || (r_state == S_WAIT && !w_rvalid)))
        r_err <= 1'b1;
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_tmo            = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_valid) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_wstrb <= cpu_wstrb;
            r_sel   <= w_sel;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_rdy) begin
            if (|r_wstrb) begin
              r_rdata <= '0;
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_state <= S_RESP;
          end
        end
        S_WAIT: begin
          if (w_rvalid) begin
            r_rdata <= w_rdata;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields are decoded from state, so an async reset clears them at once.
  always_comb begin
    m_avalid = '0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_state == S_REQ && r_sel == SLV_W'(i)) begin
        m_avalid[i]                       = 1'b1;
        m_addr[i*ADDR_W +: ADDR_W]        = r_addr;
        m_wdata[i*DATA_W +: DATA_W]       = r_wdata;
        m_wstrb[i*WSTRB_W +: WSTRB_W]     = r_wstrb;
      end
    end
  end

  assign cpu_ready = (r_state == S_RESP);
  assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_iob_native_split.sv
// Randomized bench for iob_native_split (SEL_W=2, five slaves) against a transaction-level model.
module tb_iob_native_split;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 2;
  localparam int N   = (2 ** SW) + 1;
  localparam int TMO = 16;
`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic            cpu_valid;
  logic            cpu_instr;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [3:0]      cpu_wstrb;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_ready;
  logic [N-1:0]    m_avalid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*4-1:0]  m_wstrb;
  logic [N-1:0]    m_ready;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_rvalid;
  logic            err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl_rdata;
  bit          mdl_err;

  iob_native_split #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .m_avalid(m_avalid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after cpu_ready.
  task automatic run_txn(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int rdy, input int rv,
                         input logic [31:0] rdat);
    int              sel;
    int              natural_cyc;
    int              done;
    bit              rd;
    bit              tmo;
    bit              act;
    logic [31:0]     exp_rdata;
    logic [N-1:0]    exp_av;
    logic [N*AW-1:0] exp_addr;
    logic [N*DW-1:0] exp_wdata;
    logic [N*4-1:0]  exp_wstrb;

    rd          = (wstrb == 4'h0);
    sel         = instr ? 0 : 1 + int'(addr[31:30]);
    natural_cyc = rd ? 3 + rdy + rv : 2 + rdy;
    tmo         = TMO_EN && (natural_cyc > TMO + 1);
    done        = tmo ? TMO + 1 : natural_cyc;
    exp_rdata   = (rd && !tmo) ? rdat : 32'h0;

    chk("idle_ready", cpu_ready, 1'b0);
    chk("idle_avalid", m_avalid, '0);
    chk("idle_rdata_hold", cpu_rdata, mdl_rdata);

    cpu_valid = 1'b1;
    cpu_instr = instr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;

    for (int c = 1; c <= done; c++) begin
      @(negedge clk);
      act       = (c <= 1 + rdy) && (!tmo || c <= TMO);
      exp_av    = '0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_wstrb = '0;
      if (act) begin
        exp_av[sel]              = 1'b1;
        exp_addr[sel*AW +: AW]   = addr;
        exp_wdata[sel*DW +: DW]  = wdata;
        exp_wstrb[sel*4 +: 4]    = wstrb;
      end
      chk("m_avalid", m_avalid, exp_av);
      chk("m_addr", m_addr, exp_addr);
      chk("m_wdata", m_wdata, exp_wdata);
      chk("m_wstrb", m_wstrb, exp_wstrb);
      chk("cpu_ready", cpu_ready, c == done);
      if (c == done) begin
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        if (tmo) mdl_err = 1'b1;
        chk("err", err, mdl_err);
      end

      // Fields changing after acceptance must be ignored.
      cpu_instr = 1'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_wstrb = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (i == sel) begin
          m_ready[i]          = (c == 1 + rdy);
          m_rvalid[i]         = rd && (c == 2 + rdy + rv);
          m_rdata[i*DW +: DW] = m_rvalid[i] ? rdat : $urandom;
        end else begin
          m_ready[i]          = ($urandom_range(0, 3) != 0);
          m_rvalid[i]         = ($urandom_range(0, 3) != 0);
          m_rdata[i*DW +: DW] = 32'hDEAD_BEEF;
        end
      end
      if (c == done) begin
        cpu_valid = 1'b0;
        m_ready   = '0;
        m_rvalid  = '0;
      end
    end
    mdl_rdata = exp_rdata;
    @(negedge clk);
  endtask

  initial begin
    bit          instr;
    logic [3:0]  ws;

    resetn    = 1'b0;
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_wstrb = '0;
    m_ready   = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    mdl_rdata = '0;
    mdl_err   = 1'b0;

    @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_avalid", m_avalid, '0);
    chk("rst_addr", m_addr, '0);
    chk("rst_err", err, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // Fetch on slave 0, then a write to the top data slave.
    run_txn(1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'h0000_0013);
    run_txn(1'b0, 32'hC000_0008, 32'hA5A5_A5A5, 4'hF, 0, 0, 32'h0);
    // Slave 2 stalls acceptance for five cycles.
    run_txn(1'b0, 32'h4000_0010, 32'h0BAD_F00D, 4'h3, 5, 0, 32'h0);
    // Slave 1 read while the other slaves raise stray rvalids.
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 2, 32'h1234_5678);

    // Reset asserted while waiting for read data.
    cpu_valid = 1'b1;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h0000_0080;
    cpu_wstrb = 4'h0;
    @(negedge clk);
    chk("pre_rst_avalid", m_avalid, 5'b00010);
    m_ready[1] = 1'b1;
    @(negedge clk);
    m_ready = '0;
    resetn  = 1'b0;
    #1;
    chk("arst_ready", cpu_ready, 1'b0);
    chk("arst_rdata", cpu_rdata, 32'h0);
    chk("arst_avalid", m_avalid, '0);
    chk("arst_addr", m_addr, '0);
    cpu_valid = 1'b0;
    mdl_rdata = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 1, 32'hCAFE_0001);

    // Long acceptance stall: aborted when the timeout is built in, completed otherwise.
    run_txn(1'b0, 32'h4000_0000, 32'h0, 4'h0, 30, 0, 32'h5555_AAAA);
`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
    m_rvalid = '1;
    m_rdata  = {N{32'hDEAD_BEEF}};
    @(negedge clk);
    chk("late_rv_ready", cpu_ready, 1'b0);
    chk("late_rv_rdata", cpu_rdata, 32'h0);
    m_rvalid = '0;
    run_txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, 1, 100, 32'h7777_7777);
`endif

    for (int k = 0; k < 60; k++) begin
      instr = ($urandom_range(0, 3) == 0);
      ws    = (instr || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_txn(instr, $urandom, $urandom, ws, $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        chk("gap_ready", cpu_ready, 1'b0);
        chk("gap_rdata_hold", cpu_rdata, mdl_rdata);
        @(negedge clk);
      end
    end
    chk("final_rdata_hold", cpu_rdata, mdl_rdata);
    chk("final_err", err, mdl_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
